// File: rtl/mult8u_product_accumulator.sv
// Frame accumulator for 16-bit products with a one-entry output buffer; wraps by default, clamps when MULT8U_ACC_SAT_EN is defined.
// state | meaning:  ST_IDLE | no frame open, next beat starts one;  ST_ACC | frame open, summing beats
module mult8u_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  input  logic [LEN_W-1:0] cfg_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W:0]   out_count,
  output logic             out_overflow
);

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W:0]     cnt;
  logic [LEN_W:0]     len_q;
  logic               ovf_q;

  logic [LEN_W:0]     len_eff;
  logic [LEN_W:0]     cnt_inc;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W:0]     sum_full;
  logic [ACC_W-1:0]   acc_val;
  logic               carry;
  logic               ovf_now;
  logic               closing;
  logic               accept;
  logic [LEN_W:0]     frame_len;

  // cfg_len of zero encodes the maximum frame of 2^LEN_W beats
  assign len_eff  = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
  assign cnt_inc  = cnt + 1'b1;
  assign acc_base = (state == ST_ACC) ? acc : '0;
  assign sum_full = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, in_product};
  assign carry    = sum_full[ACC_W];
  assign ovf_now  = carry | ((state == ST_ACC) & ovf_q);

`ifdef MULT8U_ACC_SAT_EN
  assign acc_val = ovf_now ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
  assign acc_val = sum_full[ACC_W-1:0];
`endif

  assign frame_len = (state == ST_IDLE) ? len_eff : len_q;
  assign in_ready  = !(closing && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    closing   = 1'b0;
    case (state)
      ST_IDLE: begin
        closing = (len_eff == {{LEN_W{1'b0}}, 1'b1});
        if (accept && !closing) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        closing = (cnt_inc == len_q);
        if (accept && closing) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A closing beat leaves acc/cnt/ovf_q cleared so the next frame starts clean
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) len_q <= len_eff;
      if (closing) begin
        acc   <= '0;
        cnt   <= '0;
        ovf_q <= 1'b0;
      end else begin
        acc   <= acc_val;
        cnt   <= cnt_inc;
        ovf_q <= ovf_now;
      end
    end
  end

  // Reload has priority over pop so a same-cycle pop/close keeps out_valid high
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else if (accept && closing) begin
      out_valid    <= 1'b1;
      out_sum      <= acc_val;
      out_count    <= frame_len;
      out_overflow <= ovf_now;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult8u_product_accumulator.sv
// Directed bench: a 24-bit instance for the main function and a 16-bit instance for overflow behaviour.
module tb_mult8u_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_product;
  logic [7:0]  cfg_len;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_overflow_a;
  logic [23:0] out_sum_a;
  logic [8:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_overflow_b;
  logic [15:0] out_sum_b;
  logic [8:0]  out_count_b;

  int checks = 0;
  int errors = 0;

`ifdef MULT8U_ACC_SAT_EN
  localparam logic [15:0] EXP_OVF2   = 16'd65535;
  localparam logic [15:0] EXP_OVF256 = 16'd65535;
`else
  localparam logic [15:0] EXP_OVF2   = 16'd64514;
  localparam logic [15:0] EXP_OVF256 = 16'd256;
`endif

  always #5 clk = ~clk;

  mult8u_product_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_product(in_product), .cfg_len(cfg_len), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_overflow(out_overflow_a));

  mult8u_product_accumulator #(.ACC_W(16), .LEN_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_product(in_product), .cfg_len(cfg_len), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_overflow(out_overflow_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_product = '0; cfg_len = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_sum_a !== 24'd0 ||
        out_count_a !== 9'd0 || out_overflow_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b, want 1 0 0 0 0",
               in_ready_a, out_valid_a, out_sum_a, out_count_a, out_overflow_a);
    end
    checks++;
    if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || out_sum_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_b: rdy=%b vld=%b sum=%0d, want 1 0 0", in_ready_b, out_valid_b, out_sum_b);
    end
  endtask

  task automatic test_frame4();
    logic [15:0] prod [4] = '{16'd100, 16'd200, 16'd300, 16'd400};
    cfg_len = 8'd4; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_product = prod[i];
      tick();
      if (i < 3) begin
        checks++;
        if (out_valid_a !== 1'b0) begin
          errors++;
          $display("FAIL frame4_early_valid beat %0d: got %b want 0", i, out_valid_a);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 24'd1000 || out_count_a !== 9'd4 || out_overflow_a !== 1'b0) begin
      errors++;
      $display("FAIL frame4_result: vld=%b sum=%0d cnt=%0d ovf=%b, want 1 1000 4 0",
               out_valid_a, out_sum_a, out_count_a, out_overflow_a);
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL frame4_single_pulse: vld=%b want 0", out_valid_a);
    end
  endtask

  task automatic test_len1_back_to_back();
    cfg_len = 8'd1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_product = 16'(5 + i);
      #1;
      checks++;
      if (in_ready_a !== 1'b1) begin
        errors++;
        $display("FAIL len1_in_ready beat %0d: got %b want 1", i, in_ready_a);
      end
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || out_sum_a !== 24'(5 + i) || out_count_a !== 9'd1) begin
        errors++;
        $display("FAIL len1_result beat %0d: vld=%b sum=%0d cnt=%0d, want 1 %0d 1",
                 i, out_valid_a, out_sum_a, out_count_a, 5 + i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL len1_drain: vld=%b want 0", out_valid_a);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] prod [4] = '{16'd100, 16'd200, 16'd7, 16'd8};
    cfg_len = 8'd2; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_product = prod[i];
      #1;
      checks++;
      if (in_ready_a !== 1'b1) begin
        errors++;
        $display("FAIL bp_in_ready beat %0d: got %b want 1", i, in_ready_a);
      end
      tick();
    end
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 24'd300 || out_count_a !== 9'd2) begin
      errors++;
      $display("FAIL bp_first_held: vld=%b sum=%0d cnt=%0d, want 1 300 2", out_valid_a, out_sum_a, out_count_a);
    end
    in_product = prod[3];
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready_a !== 1'b0 || out_sum_a !== 24'd300) begin
        errors++;
        $display("FAIL bp_stall cycle %0d: rdy=%b sum=%0d, want 0 300", i, in_ready_a, out_sum_a);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: rdy=%b want 1", in_ready_a);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 24'd15 || out_count_a !== 9'd2) begin
      errors++;
      $display("FAIL bp_second: vld=%b sum=%0d cnt=%0d, want 1 15 2", out_valid_a, out_sum_a, out_count_a);
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: vld=%b want 0", out_valid_a);
    end
  endtask

  task automatic test_overflow();
    cfg_len = 8'd2; out_ready = 1'b1;
    in_valid = 1'b1; in_product = 16'd65025;
    tick(); tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid_b !== 1'b1 || out_sum_b !== EXP_OVF2 || out_overflow_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf16: vld=%b sum=%0d ovf=%b, want 1 %0d 1", out_valid_b, out_sum_b, out_overflow_b, EXP_OVF2);
    end
    checks++;
    if (out_sum_a !== 24'd130050 || out_overflow_a !== 1'b0) begin
      errors++;
      $display("FAIL ovf24_none: sum=%0d ovf=%b, want 130050 0", out_sum_a, out_overflow_a);
    end
    tick();
  endtask

  task automatic test_full_frame();
    cfg_len = 8'd0; out_ready = 1'b1;
    in_valid = 1'b1; in_product = 16'd65025;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0) cfg_len = 8'd3;
      if (i == 2 || i == 254) begin
        checks++;
        if (out_valid_a !== 1'b0) begin
          errors++;
          $display("FAIL full_early_valid beat %0d: got %b want 0", i, out_valid_a);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_count_a !== 9'd256 || out_sum_a !== 24'd16646400 || out_overflow_a !== 1'b0) begin
      errors++;
      $display("FAIL full_a: vld=%b cnt=%0d sum=%0d ovf=%b, want 1 256 16646400 0",
               out_valid_a, out_count_a, out_sum_a, out_overflow_a);
    end
    checks++;
    if (out_count_b !== 9'd256 || out_sum_b !== EXP_OVF256 || out_overflow_b !== 1'b1) begin
      errors++;
      $display("FAIL full_b: cnt=%0d sum=%0d ovf=%b, want 256 %0d 1", out_count_b, out_sum_b, out_overflow_b, EXP_OVF256);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    cfg_len = 8'd4; out_ready = 1'b1;
    in_valid = 1'b1; in_product = 16'd50;
    tick(); tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_frame: vld=%b rdy=%b, want 0 1", out_valid_a, in_ready_a);
    end
    in_valid = 1'b1; in_product = 16'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        checks++;
        if (out_valid_a !== 1'b0) begin
          errors++;
          $display("FAIL rst_stale beat %0d: vld=%b sum=%0d want no output", i, out_valid_a, out_sum_a);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid_a !== 1'b1 || out_sum_a !== 24'd4 || out_count_a !== 9'd4) begin
      errors++;
      $display("FAIL rst_after_sum: vld=%b sum=%0d cnt=%0d, want 1 4 4", out_valid_a, out_sum_a, out_count_a);
    end
    // Pending result must be discarded by reset
    out_ready = 1'b0; cfg_len = 8'd1; in_valid = 1'b1; in_product = 16'd9;
    tick();
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || out_sum_a !== 24'd0) begin
      errors++;
      $display("FAIL rst_pending: vld=%b sum=%0d, want 0 0", out_valid_a, out_sum_a);
    end
  endtask

  initial begin
    test_reset();
    test_frame4();
    test_len1_back_to_back();
    test_backpressure();
    test_overflow();
    test_full_frame();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
